// File: rtl/control_unit_pkg.sv
// rtl/control_unit_pkg.sv - shared instruction opcodes and decode helpers
package control_unit_pkg;

  // existing ALU opcodes
  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_XOR  = 5'd1;
  localparam logic [4:0] OP_OR   = 5'd2;
  localparam logic [4:0] OP_AND  = 5'd3;
  localparam logic [4:0] OP_SUBR = 5'd4;
  localparam logic [4:0] OP_ADDR = 5'd5;
  localparam logic [4:0] OP_SR   = 5'd6;
  localparam logic [4:0] OP_SL   = 5'd7;
  localparam logic [4:0] OP_RR   = 5'd8;
  localparam logic [4:0] OP_RL   = 5'd9;
  localparam logic [4:0] OP_DEC  = 5'd10;
  localparam logic [4:0] OP_INC  = 5'd11;
  localparam logic [4:0] OP_NOT  = 5'd12;
  localparam logic [4:0] OP_SUBI = 5'd13;
  localparam logic [4:0] OP_ADDI = 5'd14;
  localparam logic [4:0] OP_LDI  = 5'd15;
  localparam logic [4:0] OP_LDR  = 5'd16;

  // sequencer-only opcodes, kept clear of the ALU codes above
  localparam logic [4:0] OP_STR  = 5'd17;
  localparam logic [4:0] OP_JMP  = 5'd18;
  localparam logic [4:0] OP_JZ   = 5'd19;
  localparam logic [4:0] OP_JLZ  = 5'd20;
  localparam logic [4:0] OP_JGZ  = 5'd21;
  localparam logic [4:0] OP_HLT  = 5'd22;

  // ops whose second operand comes from the register file
  function automatic logic is_reg_form(input logic [4:0] op);
    return (op == OP_XOR) || (op == OP_OR) || (op == OP_AND) ||
           (op == OP_SUBR) || (op == OP_ADDR) || (op == OP_LDR);
  endfunction

  // ops that write the ALU result and flags back
  function automatic logic is_alu_class(input logic [4:0] op);
    return (op >= OP_XOR) && (op <= OP_LDR);
  endfunction

endpackage

// File: rtl/control_unit_reg_file.sv
// rtl/control_unit_reg_file.sv - register file, one combinational read and one synchronous write port
module reg_file
  import control_unit_pkg::*;
#(
  parameter int REG_BIT_CNT = 3,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [REG_BIT_CNT-1:0] wr_idx,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic [REG_BIT_CNT-1:0] rd_idx,
  output logic [DATA_WIDTH-1:0]  rd_data
);

  logic [DATA_WIDTH-1:0] regs [2**REG_BIT_CNT];

  // synchronous clear on reset, otherwise single-entry write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**REG_BIT_CNT; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wr_idx] <= wr_data;
    end
  end

  assign rd_data = regs[rd_idx];

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - fetch/decode/execute sequencer driving an external ALU
module control_unit
  import control_unit_pkg::*;
#(
  parameter int UNDEFINED     = 3,
  parameter int CNTR_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 5,
  parameter int REG_BIT_CNT   = 3,
  parameter int DATA_WIDTH    = 8,
  parameter int COMBINED_DATA = ADDR_WIDTH + UNDEFINED + DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  output logic [CNTR_WIDTH-1:0]    imem_addr,
  input  logic [COMBINED_DATA-1:0] imem_data,
  output logic [ADDR_WIDTH-1:0]    alu_op,
  output logic [DATA_WIDTH-1:0]    alu_in1,
  output logic [DATA_WIDTH-1:0]    alu_in2,
  input  logic [DATA_WIDTH-1:0]    alu_result,
  input  logic                     alu_zero_f,
  input  logic                     alu_ls_z_f,
  input  logic                     alu_gr_z_f,
  output logic [DATA_WIDTH-1:0]    acc,
  output logic [2:0]               flags,
  output logic [CNTR_WIDTH-1:0]    pc,
  output logic                     halted
);

  typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} state_t;

  state_t                   state;
  logic [COMBINED_DATA-1:0] ir;
  logic [ADDR_WIDTH-1:0]    ir_op;
  logic [DATA_WIDTH-1:0]    ir_data;
  logic [4:0]               op;
  logic [REG_BIT_CNT-1:0]   reg_idx;
  logic [DATA_WIDTH-1:0]    reg_rd_data;
  logic                     reg_we;
  logic [CNTR_WIDTH-1:0]    pc_inc;
  logic [CNTR_WIDTH-1:0]    target;
  logic                     unused_reserved;

  assign ir_op           = ir[COMBINED_DATA-1 -: ADDR_WIDTH];
  assign ir_data         = ir[DATA_WIDTH-1:0];
  assign unused_reserved = ^ir[DATA_WIDTH +: UNDEFINED];
  assign op              = 5'(ir_op);
  assign reg_idx         = ir_data[REG_BIT_CNT-1:0];
  assign target          = ir_data[CNTR_WIDTH-1:0];
  assign pc_inc          = pc + 1'b1;

  assign imem_addr = pc;
  assign alu_op    = ir_op;
  assign alu_in1   = acc;
  assign alu_in2   = is_reg_form(op) ? reg_rd_data : ir_data;

  // STr commits only on an enabled EXEC edge that is not also a reset edge
  assign reg_we = en && !rst && (state == EXEC) && (op == OP_STR);

  reg_file #(
    .REG_BIT_CNT(REG_BIT_CNT),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_reg_file (
    .clk    (clk),
    .rst    (rst),
    .we     (reg_we),
    .wr_idx (reg_idx),
    .wr_data(acc),
    .rd_idx (reg_idx),
    .rd_data(reg_rd_data)
  );

  // sequencer: state, IR, accumulator, flags, pc and halt indication
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FETCH;
      pc     <= '0;
      acc    <= '0;
      flags  <= 3'b000;
      ir     <= '0;
      halted <= 1'b0;
    end else if (en) begin
      case (state)
        FETCH: state <= DECODE;
        DECODE: begin
          ir    <= imem_data;
          state <= EXEC;
        end
        EXEC: begin
          state <= FETCH;
          pc    <= pc_inc;
          if (is_alu_class(op)) begin
            acc   <= alu_result;
            flags <= {alu_gr_z_f, alu_ls_z_f, alu_zero_f};
          end else begin
            case (op)
              OP_JMP: pc <= target;
              OP_JZ:  if (flags[0]) pc <= target;
              OP_JLZ: if (flags[1]) pc <= target;
              OP_JGZ: if (flags[2]) pc <= target;
              OP_HLT: begin
                pc     <= pc;
                state  <= HALT;
                halted <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed self-checking bench for control_unit
module tb_control_unit;
  import control_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [4:0]  alu_op;
  logic [7:0]  alu_in1;
  logic [7:0]  alu_in2;
  logic [7:0]  alu_result;
  logic        alu_zero_f;
  logic        alu_ls_z_f;
  logic        alu_gr_z_f;
  logic [7:0]  acc;
  logic [2:0]  flags;
  logic [7:0]  pc;
  logic        halted;

  logic [15:0] mem [256];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  control_unit dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .alu_op    (alu_op),
    .alu_in1   (alu_in1),
    .alu_in2   (alu_in2),
    .alu_result(alu_result),
    .alu_zero_f(alu_zero_f),
    .alu_ls_z_f(alu_ls_z_f),
    .alu_gr_z_f(alu_gr_z_f),
    .acc       (acc),
    .flags     (flags),
    .pc        (pc),
    .halted    (halted)
  );

  // synchronous instruction memory
  always @(posedge clk) imem_data <= mem[imem_addr];

  // reference ALU: signed view of the result for the flags
  always_comb begin
    alu_result = alu_in1;
    case (alu_op)
      OP_XOR:          alu_result = alu_in1 ^ alu_in2;
      OP_OR:           alu_result = alu_in1 | alu_in2;
      OP_AND:          alu_result = alu_in1 & alu_in2;
      OP_SUBR, OP_SUBI: alu_result = alu_in1 - alu_in2;
      OP_ADDR, OP_ADDI: alu_result = alu_in1 + alu_in2;
      OP_SR:           alu_result = alu_in1 >> 1;
      OP_SL:           alu_result = alu_in1 << 1;
      OP_RR:           alu_result = {alu_in1[0], alu_in1[7:1]};
      OP_RL:           alu_result = {alu_in1[6:0], alu_in1[7]};
      OP_DEC:          alu_result = alu_in1 - 8'd1;
      OP_INC:          alu_result = alu_in1 + 8'd1;
      OP_NOT:          alu_result = ~alu_in1;
      OP_LDI, OP_LDR:  alu_result = alu_in2;
      default:         alu_result = alu_in1;
    endcase
  end
  assign alu_zero_f = (alu_result == 8'd0);
  assign alu_ls_z_f = alu_result[7];
  assign alu_gr_z_f = (alu_result != 8'd0) && !alu_result[7];

  function automatic logic [15:0] ins(input logic [4:0] op, input logic [7:0] d);
    return {op, 3'b000, d};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = ins(OP_NOP, 8'h00);
  endtask

  // leaves the bench in cycle 0 (first FETCH) after reset release
  task automatic start();
    en  = 1'b1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_mem();
    mem[0] = ins(OP_LDI, 8'h11);
    start();
    checks++; if (pc !== 8'd0) begin errors++; $display("FAIL reset_pc got=%0h exp=0", pc); end
    checks++; if (acc !== 8'd0) begin errors++; $display("FAIL reset_acc got=%0h exp=0", acc); end
    checks++; if (flags !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", flags); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", halted); end
    checks++; if (alu_op !== 5'd0) begin errors++; $display("FAIL reset_alu_op got=%0h exp=0", alu_op); end
    checks++; if (imem_addr !== 8'd0) begin errors++; $display("FAIL reset_imem_addr got=%0h exp=0", imem_addr); end
  endtask

  task automatic test_add_halt();
    clear_mem();
    mem[0] = ins(OP_LDI, 8'd5);
    mem[1] = ins(OP_ADDI, 8'd3);
    mem[2] = ins(OP_HLT, 8'h00);
    start();
    tick(3);
    checks++; if (acc !== 8'd5) begin errors++; $display("FAIL ldi_acc got=%0h exp=5", acc); end
    tick(3);
    checks++; if (acc !== 8'd8) begin errors++; $display("FAIL addi_acc_cycle6 got=%0h exp=8", acc); end
    tick(2);
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halted_early_cycle8 got=%b exp=0", halted); end
    tick(1);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halted_cycle9 got=%b exp=1", halted); end
    checks++; if (pc !== 8'd2) begin errors++; $display("FAIL halt_pc got=%0h exp=2", pc); end
    tick(6);
    checks++; if (pc !== 8'd2 || halted !== 1'b1) begin errors++; $display("FAIL halt_hold pc=%0h halted=%b exp pc=2 halted=1", pc, halted); end
    checks++; if (acc !== 8'd8) begin errors++; $display("FAIL halt_acc got=%0h exp=8", acc); end
  endtask

  task automatic test_jz_taken();
    clear_mem();
    mem[0] = ins(OP_LDI, 8'd3);
    mem[1] = ins(OP_SUBI, 8'd3);
    mem[2] = ins(OP_JZ, 8'd7);
    start();
    tick(6);
    checks++; if (flags !== 3'b001) begin errors++; $display("FAIL jz_flags got=%b exp=001", flags); end
    tick(3);
    checks++; if (pc !== 8'd7) begin errors++; $display("FAIL jz_pc got=%0h exp=7", pc); end
    checks++; if (flags !== 3'b001) begin errors++; $display("FAIL jz_flags_kept got=%b exp=001", flags); end
  endtask

  task automatic test_jgz_not_taken();
    clear_mem();
    mem[0] = ins(OP_LDI, 8'd1);
    mem[1] = ins(OP_SUBI, 8'd2);
    mem[2] = ins(OP_JGZ, 8'd9);
    start();
    tick(6);
    checks++; if (acc !== 8'hFF) begin errors++; $display("FAIL jgz_acc got=%0h exp=ff", acc); end
    checks++; if (flags !== 3'b010) begin errors++; $display("FAIL jgz_flags got=%b exp=010", flags); end
    tick(3);
    checks++; if (pc !== 8'd3) begin errors++; $display("FAIL jgz_pc got=%0h exp=3", pc); end
  endtask

  task automatic test_jlz_taken();
    clear_mem();
    mem[0] = ins(OP_LDI, 8'h80);
    mem[1] = ins(OP_JLZ, 8'h40);
    start();
    tick(6);
    checks++; if (pc !== 8'h40) begin errors++; $display("FAIL jlz_pc got=%0h exp=40", pc); end
  endtask

  task automatic test_store_load();
    clear_mem();
    mem[0] = ins(OP_LDI, 8'h2A);
    mem[1] = ins(OP_STR, 8'd3);
    mem[2] = ins(OP_LDI, 8'h00);
    mem[3] = ins(OP_LDR, 8'd3);
    start();
    tick(6);
    checks++; if (acc !== 8'h2A || flags !== 3'b100) begin errors++; $display("FAIL str_keeps acc=%0h flags=%b exp acc=2a flags=100", acc, flags); end
    tick(3);
    checks++; if (acc !== 8'h00) begin errors++; $display("FAIL str_ldi0 got=%0h exp=0", acc); end
    tick(3);
    checks++; if (acc !== 8'h2A) begin errors++; $display("FAIL ldr_acc got=%0h exp=2a", acc); end
  endtask

  task automatic test_jmp_wrap();
    clear_mem();
    mem[0]   = ins(OP_JMP, 8'hFF);
    mem[255] = ins(OP_NOP, 8'h00);
    start();
    tick(3);
    checks++; if (imem_addr !== 8'hFF) begin errors++; $display("FAIL jmp_addr got=%0h exp=ff", imem_addr); end
    tick(3);
    checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL wrap_addr got=%0h exp=0", imem_addr); end
  endtask

  task automatic test_stall();
    clear_mem();
    mem[0] = ins(OP_LDI, 8'd5);
    mem[1] = ins(OP_ADDI, 8'd1);
    mem[2] = ins(OP_HLT, 8'h00);
    start();
    tick(5);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      checks++; if (acc !== 8'd5 || pc !== 8'd1) begin errors++; $display("FAIL stall_hold%0d acc=%0h pc=%0h exp acc=5 pc=1", i, acc, pc); end
    end
    en = 1'b1;
    tick(1);
    checks++; if (acc !== 8'd6 || pc !== 8'd2) begin errors++; $display("FAIL stall_resume acc=%0h pc=%0h exp acc=6 pc=2", acc, pc); end
    tick(6);
    checks++; if (acc !== 8'd6 || halted !== 1'b1) begin errors++; $display("FAIL stall_once acc=%0h halted=%b exp acc=6 halted=1", acc, halted); end
  endtask

  task automatic test_back_to_back_reset();
    clear_mem();
    mem[0] = ins(OP_LDI, 8'd7);
    mem[1] = ins(OP_LDI, 8'h80);
    start();
    tick(3);
    checks++; if (acc !== 8'd7) begin errors++; $display("FAIL pre_rst_acc got=%0h exp=7", acc); end
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++; if (acc !== 8'd0 || flags !== 3'b000) begin errors++; $display("FAIL rst_mid_exec acc=%0h flags=%b exp acc=0 flags=000", acc, flags); end
    checks++; if (pc !== 8'd0 || halted !== 1'b0 || alu_op !== 5'd0) begin errors++; $display("FAIL rst_mid_exec_state pc=%0h halted=%b op=%0h exp 0", pc, halted, alu_op); end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    test_reset();
    test_add_halt();
    test_jz_taken();
    test_jgz_not_taken();
    test_jlz_taken();
    test_store_load();
    test_jmp_wrap();
    test_stall();
    test_back_to_back_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
